vit_bus_sched: RTL
==================

# vit_bus_sched

Sequencing controller and 2-way arbiter for the shared vit device bus. Two requesters issue single read/write transactions to either vit1 or vit2. The block grants one requester at a time, drives the chip selects, address, write strobe and tri-state data bus through a fixed setup/access/hold sequence, and returns read data with a completion pulse. It sits between the requesters and the `vit1_cs`/`vit2_cs`/`out_addr`/`vit_data` pins.

## Interface
- `DATA_W`, 8, data bus width
- `ADDR_W`, 3, device address width
- `ACCESS_CYC`, 2, counted access cycles with CS asserted (≥1)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  2  per-requester transaction request, level; held until `done[i]`
- `r0_vit_num`, `r1_vit_num`  in  1  target: 0=vit1, 1=vit2
- `r0_is_write`, `r1_is_write`  in  1  1=write, 0=read
- `r0_addr`, `r1_addr`  in  ADDR_W  device address
- `r0_wdata`, `r1_wdata`  in  DATA_W  write data
- `vit1_code`, `vit2_code`  in  1  device present/enabled
- `vit_cs_allow`  in  1  global access gate
- `gnt`  out  2  one-hot, high from SETUP through HOLD
- `done`  out  2  one-cycle completion pulse in HOLD
- `err`  out  1  valid with `done`; 1 = target disabled, no access made
- `rdata`  out  DATA_W  last captured read data
- `vit1_cs`, `vit2_cs`  out  1  active-high chip selects
- `out_addr`  out  ADDR_W  device address
- `vit_we`  out  1  write strobe
- `vit_data`  inout  DATA_W  shared tri-state data bus

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD. All outputs are registered.
- **IDLE**: if any `req` is high and `vit_cs_allow`=1, the arbiter picks the winner and latches its fields.
  - If the target's `vitN_code`=1, go to SETUP.
  - Otherwise go to HOLD with the error flag set.
- **Arbitration**: round-robin on `last` pointer. Reset gives priority to requester 0. The pointer updates to the winner on each grant, including error grants.
- **SETUP** (1 cycle): `gnt`, `out_addr` and `vit_we`=is_write are valid. CS is low. For writes, wdata is driven onto `vit_data`.
- **ACCESS**: the target CS is high. A down-counter is loaded with ACCESS_CYC and decrements only on cycles with `vit_cs_allow`=1.
  - While `vit_cs_allow`=0, the counter freezes and CS stays high.
  - A read captures `vit_data` into `rdata` on the cycle where counter==1 and allow=1, then goes to HOLD.
- **HOLD** (1 cycle): CS is low. Addr, we and write data are still held. `done[winner]`=1 and `err` is valid. Next state is IDLE.
- **Data bus**: driven only for writes, during SETUP..HOLD. High-Z otherwise.
- **Error path**: CS and `vit_we` are never asserted. `rdata` is unchanged.
- A requester dropping `req` mid-transaction is ignored; the transaction completes.

## Timing
- Reset values: `vit1_cs`=`vit2_cs`=0, `vit_we`=0, `out_addr`=0, `gnt`=0, `done`=0, `err`=0, `rdata`=0, `vit_data`=Z, state IDLE, `last` favours r0.
- Request sampled in IDLE at edge N:
  - SETUP in cycle N+1.
  - ACCESS in N+2..N+1+ACCESS_CYC (no stalls).
  - HOLD/`done` in N+2+ACCESS_CYC.
  - IDLE in N+3+ACCESS_CYC.
- Throughput: ACCESS_CYC+3 cycles per transaction. Default is 5.
- Error latency: `done`/`err` in cycle N+1.
- Each stalled cycle (allow=0 in ACCESS) adds exactly 1 cycle.
- Simultaneous `req`=2'b11 in IDLE: grant goes to the requester ≠ `last`. The loser is served in the next IDLE.
- `reset` mid-transaction: all outputs take reset values at the next edge. No `done` pulse. The bus is released.

## Structure
- Package `vit_bus_pkg` holds:
  - state enum `vit_state_t`
  - DATA_W/ADDR_W default constants
  - `VIT1`/`VIT2` select constants
- Sub-module `vit_rr_arb`: 2-way round-robin arbiter. Inputs are req[1:0] and an advance strobe; outputs are the one-hot winner and the `last` pointer.

## Test plan
- **Write**: r0 writes vit1, addr 3'b010, data 8'hAB, codes=1, allow=1.
  - SETUP 1 cycle, then `vit1_cs` high exactly 2 cycles.
  - `vit_data`=8'hAB and `vit_we`=1 through HOLD.
  - `done[0]` at N+4, `err`=0.
- **Read**: r1 reads vit2, addr 3'b101, bench drives 8'h5C during ACCESS.
  - `rdata`=8'h5C.
  - `vit_data` is never driven by the DUT.
- **Contention**: `req`=2'b11 held after reset.
  - Grants alternate r0, r1, r0.
  - Transaction completions are 5 cycles apart.
- **Disabled device**: `vit1_code`=0, r0 targets vit1.
  - `done[0]`=1 and `err`=1 at N+1.
  - CS never asserted; `rdata` unchanged.
- **Gated access**: allow=0 in IDLE, then high.
  - No grant while allow=0.
  - Dropping allow for 3 cycles mid-ACCESS extends CS-high to 5 cycles.
- **Reset mid-access**: `reset` asserted in ACCESS.
  - Next cycle: CS=0, `gnt`=0, `done`=0, bus Z.
  - After reset, a `req`=2'b11 tie grants r0 first.

Source files
------------

// File: rtl/vit_bus_pkg.sv
// Shared types and constants for the vit device bus scheduler.
package vit_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StHold
    } vit_state_t;

    localparam int unsigned VIT_DATA_W = 8;
    localparam int unsigned VIT_ADDR_W = 3;

    localparam logic VIT1 = 1'b0;
    localparam logic VIT2 = 1'b1;

endpackage

// File: rtl/vit_rr_arb.sv
// Two-way round-robin arbiter; the last granted requester loses a tie.
module vit_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] win_o,
    output logic       last_o
);

    logic last_q, last_d;

    always_comb begin
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = last_q ? 2'b01 : 2'b10;
            default: win_o = 2'b00;
        endcase
        last_d = last_q;
        if (adv_i && (win_o != 2'b00)) begin
            last_d = win_o[1];
        end
    end

    // Reset value points at r1 so that r0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/vit_bus_sched.sv
// Arbitrates two requesters onto the shared vit bus and sequences
// each transaction through setup, counted access and hold phases.
module vit_bus_sched
    import vit_bus_pkg::*;
#(
    parameter int unsigned DATA_W     = VIT_DATA_W,
    parameter int unsigned ADDR_W     = VIT_ADDR_W,
    parameter int unsigned ACCESS_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic              r0_vit_num,
    input  logic              r1_vit_num,
    input  logic              r0_is_write,
    input  logic              r1_is_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              vit1_code,
    input  logic              vit2_code,
    input  logic              vit_cs_allow,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              vit1_cs,
    output logic              vit2_cs,
    output logic [ADDR_W-1:0] out_addr,
    output logic              vit_we,
    inout  wire  [DATA_W-1:0] vit_data
);

    localparam int unsigned CntW = $clog2(ACCESS_CYC + 1);

    vit_state_t        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              tgt_q, tgt_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cs1_q, cs1_d;
    logic              cs2_q, cs2_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              drv_q, drv_d;

    logic [1:0]        win;
    logic              arb_adv;
    logic              arb_last_unused;

    logic              sel_vit, sel_wr, sel_code;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    vit_rr_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req),
        .adv_i  (arb_adv),
        .win_o  (win),
        .last_o (arb_last_unused)
    );

    always_comb begin
        sel_vit   = win[1] ? r1_vit_num  : r0_vit_num;
        sel_wr    = win[1] ? r1_is_write : r0_is_write;
        sel_addr  = win[1] ? r1_addr     : r0_addr;
        sel_wdata = win[1] ? r1_wdata    : r0_wdata;
        sel_code  = (sel_vit == VIT2) ? vit2_code : vit1_code;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        cs1_d   = 1'b0;
        cs2_d   = 1'b0;
        addr_d  = addr_q;
        we_d    = we_q;
        drv_d   = drv_q;
        arb_adv = 1'b0;

        case (state_q)
            StIdle: begin
                gnt_d = 2'b00;
                we_d  = 1'b0;
                drv_d = 1'b0;
                if ((req != 2'b00) && vit_cs_allow) begin
                    arb_adv = 1'b1;
                    gnt_d   = win;
                    tgt_d   = sel_vit;
                    wr_d    = sel_wr;
                    wdata_d = sel_wdata;
                    addr_d  = sel_addr;
                    if (sel_code) begin
                        state_d = StSetup;
                        we_d    = sel_wr;
                        drv_d   = sel_wr;
                    end else begin
                        // Disabled target: report straight away, never touch the bus.
                        state_d = StHold;
                        done_d  = win;
                        err_d   = 1'b1;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = CntW'(ACCESS_CYC);
                cs1_d   = (tgt_q == VIT1);
                cs2_d   = (tgt_q == VIT2);
            end
            StAccess: begin
                cs1_d = cs1_q;
                cs2_d = cs2_q;
                if (vit_cs_allow) begin
                    if (cnt_q == CntW'(1)) begin
                        state_d = StHold;
                        cs1_d   = 1'b0;
                        cs2_d   = 1'b0;
                        done_d  = gnt_q;
                        if (!wr_q) begin
                            rdata_d = vit_data;
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StHold: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
                we_d    = 1'b0;
                drv_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cs1_q   <= 1'b0;
            cs2_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cs1_q   <= cs1_d;
            cs2_q   <= cs2_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            drv_q   <= drv_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign vit1_cs  = cs1_q;
    assign vit2_cs  = cs2_q;
    assign out_addr = addr_q;
    assign vit_we   = we_q;
    assign vit_data = drv_q ? wdata_q : {DATA_W{1'bz}};

endmodule
